chu_avalon_ddfs_sweep_master: RTL and testbench
===============================================

Name: chu_avalon_ddfs_sweep_master

Overview:
- Avalon-MM master that programs the DDFS slave register block to run an autonomous linear frequency sweep.
- On start it performs a setup sequence: write envelope, then focw=0, then pha=0.
- It then writes sweep_len successive fccw values, each held for dwell_len cycles.
- Sits between a control processor (or test harness) and the DDFS slave port on the same fabric.

Parameters:
ADDR_W, 9, Avalon address width (matches DDFS slave)
LEN_W, 16, width of sweep step count
DWELL_W, 24, width of dwell counter
A_FCCW, 9'h000, fccw register address
A_FOCW, 9'h001, focw register address
A_PHA, 9'h002, pha register address
A_ENV, 9'h003, env register address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  single-cycle request to begin a sweep
abort  in  1  terminate sweep early
fccw_start  in  26  first carrier control word
fccw_step  in  26  increment added per step
sweep_len  in  LEN_W  number of fccw writes
dwell_len  in  DWELL_W  idle cycles after each fccw write
env_val  in  16  envelope value written during setup
busy  out  1  high from the cycle after start is accepted until return to IDLE
done_tick  out  1  one-cycle pulse on normal completion
cur_fccw  out  26  last fccw value accepted by the slave
avm_address  out  ADDR_W  master address
avm_chipselect  out  1  asserted together with avm_write
avm_write  out  1  write request
avm_writedata  out  32  write data, zero-extended
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; busy=0, done_tick=0, cur_fccw=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0. Reset overrides everything, including mid-transfer; this is the only case in which a pending write may be dropped.
- States: IDLE, WR_ENV, WR_FOCW, WR_PHA, WR_FCCW, DWELL, FIN.
- IDLE:
  - start=1 latches fccw_start, fccw_step, sweep_len, dwell_len and env_val.
  - Moves to WR_ENV the next cycle.
  - start is ignored in every other state.
- Write states:
  - avm_write=avm_chipselect=1; address and data are registered outputs.
  - WR_ENV: A_ENV, {16'b0, env}. WR_FOCW: A_FOCW, 0. WR_PHA: A_PHA, 0. WR_FCCW: A_FCCW, {6'b0, fccw}.
  - A transfer completes on an edge where avm_write=1 and avm_waitrequest=0.
  - While waitrequest=1, address, data and write are held stable.
  - After completion the next write state drives its request in the immediately following cycle; back-to-back writes are allowed.
  - Unstalled setup takes exactly 3 cycles.
- Transitions:
  - WR_ENV→WR_FOCW→WR_PHA.
  - WR_PHA→WR_FCCW if sweep_len≠0, else FIN.
- WR_FCCW completion:
  - cur_fccw←fccw; fccw←fccw+step, modulo 2^26 (wrap, no saturation); remaining count decrements.
  - Next state is DWELL if dwell_len≠0; else WR_FCCW (another step remains) or FIN (last step).
- DWELL:
  - avm_write=0 for exactly dwell_len cycles.
  - Then WR_FCCW if steps remain, else FIN.
- FIN: done_tick=1 for one cycle, then IDLE; busy deasserts the same edge it enters IDLE.
- Abort:
  - Sampled every busy cycle.
  - In DWELL or FIN-pending: go to IDLE next cycle.
  - In a write state: the current transfer runs to completion (Avalon rule), then IDLE.
  - Aborted sweeps never pulse done_tick; cur_fccw keeps the last accepted value.
  - abort and start together in IDLE: start wins and abort is ignored.
- avm_write is never asserted in IDLE, DWELL or FIN.

Test Plan:
- No stall: fccw_start=0x100, step=0x10, sweep_len=3, dwell_len=2, env=0x7fff → writes (3,0x7fff), (1,0), (2,0), (0,0x100), 2 idle, (0,0x110), 2 idle, (0,0x120), 2 idle; done_tick on the following cycle; cur_fccw=0x120.
- Waitrequest held high 4 cycles on the focw write → address/data/write stable for all 4 cycles, exactly one focw transfer counted, sequence otherwise unchanged.
- fccw_start=0x3FFFFF0, step=0x20, sweep_len=2, dwell_len=0 → fccw writes 0x3FFFFF0 then 0x0000010 on consecutive cycles (wrap verified).
- sweep_len=0 → only the 3 setup writes, done_tick, busy low; no A_FCCW write.
- abort while fccw write is stalled → write completes after waitrequest drops, then IDLE, no done_tick; abort during DWELL → IDLE next cycle.
- reset=0 asserted during stalled write → all outputs zero next edge, busy=0; start while busy ignored (second start mid-sweep has no effect).

Source files
------------

// File: rtl/chu_avalon_ddfs_sweep_master_if.sv
// rtl/chu_avalon_ddfs_sweep_master_if.sv - Avalon-MM write bus between sweep master and DDFS slave
interface chu_avalon_ddfs_sweep_master_if #(
  parameter int ADDR_W = 9
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write,
    input  writedata,
    output waitrequest
  );
endinterface

// File: rtl/chu_avalon_ddfs_sweep_master.sv
// rtl/chu_avalon_ddfs_sweep_master.sv - Avalon-MM master programming a DDFS linear frequency sweep
module chu_avalon_ddfs_sweep_master #(
  parameter int                ADDR_W  = 9,
  parameter int                LEN_W   = 16,
  parameter int                DWELL_W = 24,
  parameter logic [ADDR_W-1:0] A_FCCW  = 9'h000,
  parameter logic [ADDR_W-1:0] A_FOCW  = 9'h001,
  parameter logic [ADDR_W-1:0] A_PHA   = 9'h002,
  parameter logic [ADDR_W-1:0] A_ENV   = 9'h003
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [25:0]        fccw_start,
  input  logic [25:0]        fccw_step,
  input  logic [LEN_W-1:0]   sweep_len,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic [15:0]        env_val,
  output logic               busy,
  output logic               done_tick,
  output logic [25:0]        cur_fccw,
  chu_avalon_ddfs_sweep_master_if.master avm
);

  typedef enum logic [2:0] {
    IDLE, WR_ENV, WR_FOCW, WR_PHA, WR_FCCW, DWELL, FIN
  } state_t;

  state_t             state, state_nx;
  logic [25:0]        fccw_r, step_r, fccw_nx;
  logic [LEN_W-1:0]   rem_r;
  logic [DWELL_W-1:0] dwell_r, dwell_cnt;
  logic [15:0]        env_r, env_src;
  logic               abort_pend, abort_hit, xfer, in_write;
  logic               write_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic [31:0]        data_nx;

  assign xfer      = avm.write & ~avm.waitrequest;
  assign abort_hit = abort | abort_pend;
  assign in_write  = (state == WR_ENV) || (state == WR_FOCW) ||
                     (state == WR_PHA) || (state == WR_FCCW);
  // The env word is driven the same edge it is latched, so bypass the register from IDLE.
  assign env_src   = (state == IDLE) ? env_val : env_r;

  always_comb begin
    state_nx = state;
    fccw_nx  = fccw_r;
    case (state)
      IDLE:    if (start) state_nx = WR_ENV;
      WR_ENV:  if (xfer) state_nx = abort_hit ? IDLE : WR_FOCW;
      WR_FOCW: if (xfer) state_nx = abort_hit ? IDLE : WR_PHA;
      WR_PHA: begin
        if (xfer) begin
          if (abort_hit)             state_nx = IDLE;
          else if (rem_r != '0)      state_nx = WR_FCCW;
          else                       state_nx = FIN;
        end
      end
      WR_FCCW: begin
        if (xfer) begin
          fccw_nx = fccw_r + step_r;
          if (abort_hit)             state_nx = IDLE;
          else if (dwell_r != '0)    state_nx = DWELL;
          else if (rem_r > LEN_W'(1)) state_nx = WR_FCCW;
          else                       state_nx = FIN;
        end
      end
      DWELL: begin
        if (abort)                          state_nx = IDLE;
        else if (dwell_cnt == DWELL_W'(1))  state_nx = (rem_r != '0) ? WR_FCCW : FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered, so they are computed from the state being entered.
  always_comb begin
    write_nx = 1'b0;
    addr_nx  = '0;
    data_nx  = '0;
    case (state_nx)
      WR_ENV:  begin write_nx = 1'b1; addr_nx = A_ENV;  data_nx = {16'b0, env_src}; end
      WR_FOCW: begin write_nx = 1'b1; addr_nx = A_FOCW; end
      WR_PHA:  begin write_nx = 1'b1; addr_nx = A_PHA;  end
      WR_FCCW: begin write_nx = 1'b1; addr_nx = A_FCCW; data_nx = {6'b0, fccw_nx}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done_tick      <= 1'b0;
      cur_fccw       <= '0;
      avm.write      <= 1'b0;
      avm.chipselect <= 1'b0;
      avm.address    <= '0;
      avm.writedata  <= '0;
      fccw_r         <= '0;
      step_r         <= '0;
      rem_r          <= '0;
      dwell_r        <= '0;
      dwell_cnt      <= '0;
      env_r          <= '0;
      abort_pend     <= 1'b0;
    end else begin
      state          <= state_nx;
      busy           <= (state_nx != IDLE);
      done_tick      <= (state_nx == FIN);
      avm.write      <= write_nx;
      avm.chipselect <= write_nx;
      avm.address    <= addr_nx;
      avm.writedata  <= data_nx;
      fccw_r         <= fccw_nx;
      if (state == IDLE && start) begin
        fccw_r     <= fccw_start;
        step_r     <= fccw_step;
        rem_r      <= sweep_len;
        dwell_r    <= dwell_len;
        env_r      <= env_val;
        abort_pend <= 1'b0;
      end else begin
        // An abort seen mid-stall must survive until the transfer completes.
        if (in_write && abort) abort_pend <= 1'b1;
        if (state == WR_FCCW && xfer) begin
          cur_fccw  <= fccw_r;
          rem_r     <= rem_r - LEN_W'(1);
          dwell_cnt <= dwell_r;
        end else if (state == DWELL) begin
          dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_chu_avalon_ddfs_sweep_master.sv
// tb/tb_chu_avalon_ddfs_sweep_master.sv - directed self-checking bench for the DDFS sweep master
module tb_chu_avalon_ddfs_sweep_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [25:0] fccw_start = '0, fccw_step = '0;
  logic [15:0] sweep_len = '0;
  logic [23:0] dwell_len = '0;
  logic [15:0] env_val = '0;
  logic        busy, done_tick;
  logic [25:0] cur_fccw;

  chu_avalon_ddfs_sweep_master_if #(.ADDR_W(9)) avm_bus ();

  chu_avalon_ddfs_sweep_master dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .fccw_start(fccw_start), .fccw_step(fccw_step), .sweep_len(sweep_len),
    .dwell_len(dwell_len), .env_val(env_val), .busy(busy), .done_tick(done_tick),
    .cur_fccw(cur_fccw), .avm(avm_bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_bad = 0;
  int          cyc = 0;
  logic [8:0]  log_a[$];
  logic [31:0] log_d[$];
  int          log_c[$];
  int          done_cnt = 0, done_edge = 0;
  logic [8:0]  stall_addr = '0;
  int          stall_left = 0;
  logic        was_stalled = 1'b0;
  logic [8:0]  snap_a;
  logic [31:0] snap_d;
  int          start_edge, idle_edge;

  always @(posedge clk) begin
    if (avm_bus.write && !avm_bus.waitrequest) begin
      log_a.push_back(avm_bus.address);
      log_d.push_back(avm_bus.writedata);
      log_c.push_back(cyc);
    end
    if (done_tick) begin
      done_cnt++;
      done_edge = cyc;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (was_stalled && reset) begin
      chk("hold_wr", avm_bus.write, 1'b1);
      chk("hold_addr", avm_bus.address, snap_a);
      chk("hold_data", avm_bus.writedata, snap_d);
    end
    if (avm_bus.write && avm_bus.address == stall_addr && stall_left > 0) begin
      avm_bus.waitrequest = 1'b1;
      stall_left--;
      snap_a = avm_bus.address;
      snap_d = avm_bus.writedata;
    end else begin
      avm_bus.waitrequest = 1'b0;
    end
    was_stalled = avm_bus.waitrequest;
  endtask

  task automatic clr();
    log_a.delete(); log_d.delete(); log_c.delete();
    done_cnt = 0;
  endtask

  task automatic go(input logic [25:0] fs, input logic [25:0] st, input logic [15:0] ln,
                    input logic [23:0] dw, input logic [15:0] ev);
    clr();
    fccw_start = fs; fccw_step = st; sweep_len = ln; dwell_len = dw; env_val = ev;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_edge = cyc - 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    idle_edge = cyc - 1;
  endtask

  task automatic chk_wr(input int i, input logic [8:0] a, input logic [31:0] d);
    if (i < log_a.size()) begin
      chk($sformatf("wr%0d_addr", i), log_a[i], a);
      chk($sformatf("wr%0d_data", i), log_d[i], d);
    end else begin
      chk($sformatf("wr%0d_missing", i), 1'b0, 1'b1);
    end
  endtask

  task automatic chk_basic(input string tag, input int extra);
    chk({tag, "_nwr"}, log_a.size(), 6);
    chk_wr(0, 9'h3, 32'h7fff);
    chk_wr(1, 9'h1, 32'h0);
    chk_wr(2, 9'h2, 32'h0);
    chk_wr(3, 9'h0, 32'h100);
    chk_wr(4, 9'h0, 32'h110);
    chk_wr(5, 9'h0, 32'h120);
    if (log_c.size() == 6) begin
      chk({tag, "_env_lat"}, log_c[0] - start_edge, 1 + 0);
      chk({tag, "_gap1"}, log_c[4] - log_c[3], 3);
      chk({tag, "_gap2"}, log_c[5] - log_c[4], 3);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_edge"}, done_edge - start_edge, 13 + extra);
    chk({tag, "_cur"}, cur_fccw, 26'h120);
  endtask

  initial begin
    int n;
    avm_bus.waitrequest = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_tick, 1'b0);
    chk("rst_cur", cur_fccw, 26'h0);
    chk("rst_wr", avm_bus.write, 1'b0);
    chk("rst_cs", avm_bus.chipselect, 1'b0);
    chk("rst_addr", avm_bus.address, 9'h0);
    chk("rst_data", avm_bus.writedata, 32'h0);
    reset = 1'b1;
    tick();

    // basic sweep, no stall
    go(26'h100, 26'h10, 16'd3, 24'd2, 16'h7fff);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cs", avm_bus.chipselect, 1'b1);
    wait_idle();
    chk_basic("t1", 0);
    chk("t1_idle_edge", idle_edge, done_edge);

    // 4-cycle stall on focw
    stall_addr = 9'h1; stall_left = 4;
    go(26'h100, 26'h10, 16'd3, 24'd2, 16'h7fff);
    wait_idle();
    chk_basic("t2", 4);
    chk("t2_stall_used", stall_left, 0);

    // wrap, zero dwell
    go(26'h3FFFFF0, 26'h20, 16'd2, 24'd0, 16'h0001);
    wait_idle();
    chk("t3_nwr", log_a.size(), 5);
    chk_wr(3, 9'h0, 32'h3FFFFF0);
    chk_wr(4, 9'h0, 32'h0000010);
    if (log_c.size() == 5) chk("t3_b2b", log_c[4] - log_c[3], 1);
    chk("t3_done_edge", done_edge - start_edge, 6);
    chk("t3_cur", cur_fccw, 26'h10);

    // zero-length sweep
    go(26'h55, 26'h1, 16'd0, 24'd3, 16'h1234);
    wait_idle();
    chk("t4_nwr", log_a.size(), 3);
    chk_wr(0, 9'h3, 32'h1234);
    chk_wr(2, 9'h2, 32'h0);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_edge", done_edge - start_edge, 4);

    // abort during stalled fccw write
    stall_addr = 9'h0; stall_left = 3;
    go(26'h100, 26'h10, 16'd3, 24'd2, 16'h7fff);
    n = 0;
    while (!avm_bus.waitrequest && n < 50) begin tick(); n++; end
    chk("t5_stall_seen", avm_bus.waitrequest, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    chk("t5_nwr", log_a.size(), 4);
    chk_wr(3, 9'h0, 32'h100);
    if (log_c.size() == 4) chk("t5_idle_edge", idle_edge, log_c[3]);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_cur", cur_fccw, 26'h100);

    // abort during dwell
    go(26'h200, 26'h4, 16'd3, 24'd5, 16'h0002);
    n = 0;
    while (log_a.size() < 4 && n < 50) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_wr", avm_bus.write, 1'b0);
    repeat (8) tick();
    chk("t6_nwr", log_a.size(), 4);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_cur", cur_fccw, 26'h200);

    // second start mid-sweep is ignored
    go(26'h100, 26'h10, 16'd3, 24'd2, 16'h7fff);
    repeat (4) tick();
    fccw_start = 26'h999; sweep_len = 16'd1; dwell_len = 24'd0; env_val = 16'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    chk_basic("t7", 0);

    // reset during stalled write
    stall_addr = 9'h1; stall_left = 10;
    go(26'h100, 26'h10, 16'd3, 24'd2, 16'h7fff);
    n = 0;
    while (!avm_bus.waitrequest && n < 50) begin tick(); n++; end
    reset = 1'b0;
    tick();
    chk("t8_busy", busy, 1'b0);
    chk("t8_wr", avm_bus.write, 1'b0);
    chk("t8_cs", avm_bus.chipselect, 1'b0);
    chk("t8_addr", avm_bus.address, 9'h0);
    chk("t8_data", avm_bus.writedata, 32'h0);
    chk("t8_cur", cur_fccw, 26'h0);
    stall_left = 0;
    reset = 1'b1;
    repeat (4) tick();
    chk("t8_stay_idle", busy, 1'b0);
    chk("t8_done_cnt", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
